// File: rtl/buzzer_pkg.sv
// Shared definitions for the Morse buzzer sequencer: symbol codes, FSM states,
// unit lengths and a ready-made SOS pattern.
// Pure constants and types; no logic, no latency.
package buzzer_pkg;

  // Two-bit symbol codes; symbol i of a pattern sits in bits [2i+1:2i]
  localparam logic [1:0] SYM_END  = 2'b00;
  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b10;
  localparam logic [1:0] SYM_WGAP = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ON   = 3'd1,
    GAP  = 3'd2,
    WGAP = 3'd3,
    REST = 3'd4
  } state_t;

  // Durations in Morse units
  localparam int DOT_UNITS  = 1;
  localparam int DASH_UNITS = 3;
  localparam int GAP_UNITS  = 1;
  localparam int WGAP_UNITS = 6;

  // "...---..." then end: symbols 0-2 dot, 3-5 dash, 6-8 dot
  localparam logic [17:0] SOS_PATTERN = 18'h15A95;

endpackage

// File: rtl/buzzer_unit_tick.sv
// Morse unit divider: counts 0..UNIT_CYC-1 and flags the last two cycles of a unit.
// Tick flags are combinational from the count register; 0 cycles added latency.
// No backpressure; a synchronous clear holds the count at 0.
module buzzer_unit_tick #(
  parameter int UNIT_CYC = 10_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick,
  output logic o_pre_tick
);

  localparam int CW = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;

  logic [CW-1:0] r_cnt;

  // Free-running unit counter, wraps at the end of each unit
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt == CW'(UNIT_CYC - 1)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick     = (r_cnt == CW'(UNIT_CYC - 1));
  // One cycle early, so registered end-of-pass flags can line up with the last cycle
  assign o_pre_tick = (r_cnt == CW'(UNIT_CYC - 2));

endmodule

// File: rtl/buzzer_morse_seq.sv
// Morse-pattern buzzer sequencer (dot/dash/word gap, optional auto-repeat); BUZZER_TONE_EN adds a tone divider.
// Start sampled at edge k -> Busy and first symbol level from cycle k+1; all outputs registered.
// No backpressure: Stop aborts within 1 cycle, Start while busy is ignored.
module buzzer_morse_seq
  import buzzer_pkg::*;
#(
  parameter int UNIT_CYC      = 10_000_000,
  parameter int SYM_N         = 16,
  parameter int REST_UNITS    = 7,
  parameter int TONE_HALF_CYC = 12_500
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               Start_Sig,
  input  logic               Stop_Sig,
  input  logic               Repeat_En,
  input  logic [2*SYM_N-1:0] Pattern,
  output logic               Busy_Sig,
  output logic               Done_Sig,
  output logic               Buzz_En_Sig,
  output logic               Buzz_Out
);

  localparam int REST_W = $clog2(REST_UNITS + 1);
  localparam int CNT_W  = (REST_W > 3) ? REST_W : 3;
  localparam int IDX_W  = $clog2(SYM_N + 1);

  if (UNIT_CYC < 2 || REST_UNITS < 1 || TONE_HALF_CYC < 1) begin : g_param_chk
    $error("buzzer_morse_seq: UNIT_CYC >= 2, REST_UNITS >= 1, TONE_HALF_CYC >= 1");
  end

  state_t             r_state, w_nxt_state, w_dec_state;
  logic [CNT_W-1:0]   r_units, r_target, w_nxt_target, w_dec_target;
  logic [IDX_W-1:0]   r_idx, w_nxt_idx, w_dec_idx;
  logic [2*SYM_N-1:0] r_pat;
  logic               r_rep;
  logic [1:0]         w_dec_sym;
  logic               w_tick, w_pre_tick, w_unit_last, w_pre_last, w_done_nxt;
  logic               r_busy, r_done, r_buzz_en;

  // Out-of-range index reads as end code, so a full pattern ends at SYM_N
  function automatic logic [1:0] sym_at(input logic [2*SYM_N-1:0] pat,
                                        input logic [IDX_W-1:0]   idx);
    sym_at = SYM_END;
    for (int i = 0; i < SYM_N; i++) begin
      if (idx == IDX_W'(i)) sym_at = pat[2*i +: 2];
    end
  endfunction

  buzzer_unit_tick #(.UNIT_CYC(UNIT_CYC)) u_tick (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_clr      (r_state == IDLE),
    .o_tick     (w_tick),
    .o_pre_tick (w_pre_tick)
  );

  assign w_unit_last = w_tick     && (r_units == r_target - 1'b1);
  assign w_pre_last  = w_pre_tick && (r_units == r_target - 1'b1);

  // Decode the symbol that follows the current state: symbol 0 from IDLE/REST, else the next index
  always_comb begin
    w_dec_sym    = SYM_END;
    w_dec_idx    = '0;
    w_dec_state  = IDLE;
    w_dec_target = '0;
    if (r_state == IDLE) begin
      w_dec_sym = sym_at(Pattern, '0);
    end else if (r_state == REST) begin
      w_dec_sym = sym_at(r_pat, '0);
    end else begin
      w_dec_idx = r_idx + 1'b1;
      w_dec_sym = sym_at(r_pat, w_dec_idx);
    end
    case (w_dec_sym)
      SYM_DOT:  begin w_dec_state = ON;   w_dec_target = CNT_W'(DOT_UNITS);  end
      SYM_DASH: begin w_dec_state = ON;   w_dec_target = CNT_W'(DASH_UNITS); end
      SYM_WGAP: begin w_dec_state = WGAP; w_dec_target = CNT_W'(WGAP_UNITS); end
      default: begin
        // End of pass; an empty pattern never enters REST
        if (r_state != IDLE && r_rep) begin
          w_dec_state  = REST;
          w_dec_target = CNT_W'(REST_UNITS);
        end
      end
    endcase
  end

  // Next-state logic; Done is flagged one cycle ahead so the registered pulse hits the last busy cycle
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_target = r_target;
    w_nxt_idx    = r_idx;
    w_done_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (Start_Sig) begin
          w_nxt_state  = w_dec_state;
          w_nxt_target = w_dec_target;
          w_nxt_idx    = '0;
          w_done_nxt   = (w_dec_sym == SYM_END);
        end
      end
      ON: begin
        if (w_unit_last) begin
          w_nxt_state  = GAP;
          w_nxt_target = CNT_W'(GAP_UNITS);
        end
      end
      GAP, WGAP: begin
        w_done_nxt = w_pre_last && (w_dec_sym == SYM_END);
        if (w_unit_last) begin
          w_nxt_state  = w_dec_state;
          w_nxt_target = w_dec_target;
          w_nxt_idx    = w_dec_idx;
        end
      end
      REST: begin
        if (w_unit_last) begin
          w_nxt_state  = w_dec_state;
          w_nxt_target = w_dec_target;
          w_nxt_idx    = '0;
        end
      end
      default: w_nxt_state = IDLE;
    endcase
    if (Stop_Sig) begin
      w_nxt_state = IDLE;
      w_done_nxt  = 1'b0;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_target  <= '0;
      r_idx     <= '0;
      r_units   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_buzz_en <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_target <= w_nxt_target;
      r_idx    <= w_nxt_idx;
      if (r_state == IDLE || w_unit_last || w_nxt_state != r_state) begin
        r_units <= '0;
      end else if (w_tick) begin
        r_units <= r_units + 1'b1;
      end
      r_busy    <= (w_nxt_state != IDLE);
      r_done    <= w_done_nxt;
      r_buzz_en <= (w_nxt_state == ON);
    end
  end

  // Pattern and repeat mode are captured only by an accepted start
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pat <= '0;
      r_rep <= 1'b0;
    end else if (r_state == IDLE && Start_Sig && !Stop_Sig) begin
      r_pat <= Pattern;
      r_rep <= Repeat_En;
    end
  end

  assign Busy_Sig    = r_busy;
  assign Done_Sig    = r_done;
  assign Buzz_En_Sig = r_buzz_en;

`ifdef BUZZER_TONE_EN
  localparam int TONE_W = (TONE_HALF_CYC > 1) ? $clog2(TONE_HALF_CYC) : 1;

  logic [TONE_W-1:0] r_tone_cnt;
  logic              r_tone;

  // Square wave restarted high at each ON entry, forced low outside ON
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tone_cnt <= '0;
      r_tone     <= 1'b0;
    end else if (w_nxt_state == ON && r_state != ON) begin
      r_tone_cnt <= '0;
      r_tone     <= 1'b1;
    end else if (w_nxt_state == ON) begin
      if (r_tone_cnt == TONE_W'(TONE_HALF_CYC - 1)) begin
        r_tone_cnt <= '0;
        r_tone     <= ~r_tone;
      end else begin
        r_tone_cnt <= r_tone_cnt + 1'b1;
      end
    end else begin
      r_tone_cnt <= '0;
      r_tone     <= 1'b0;
    end
  end

  assign Buzz_Out = r_tone;
`else
  assign Buzz_Out = r_buzz_en;
`endif

endmodule
